// File: rtl/tsu_ts_arbiter.sv
// Merges RX/TX PTP time-stamp records into the single ptp_queue write port.
// Optional build macro TSU_ARB_RX_PRIORITY_EN selects fixed RX priority instead of round-robin.

module tsu_ts_arbiter_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 52
) (
  input  logic             gmii_clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define valid entries.
  always_ff @(posedge gmii_clk) begin
    if (push && !full) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

module tsu_ts_arbiter #(
  parameter int DEPTH_LOG2   = 2,
  parameter int Q_FULL_LEVEL = 15
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        rx_found,
  input  logic [51:0] rx_infor,
  input  logic        tx_found,
  input  logic [51:0] tx_infor,
  input  logic [3:0]  q_wrusedw,
  output logic        q_wr_en,
  output logic [55:0] q_wr_data,
  output logic [7:0]  rx_drop_cnt,
  output logic [7:0]  tx_drop_cnt,
  input  logic        clr_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [4:0] Q_LIMIT = 5'(Q_FULL_LEVEL);

  state_t      state;
  state_t      next_state;
  logic        rx_empty;
  logic        rx_full;
  logic        tx_empty;
  logic        tx_full;
  logic [51:0] rx_head;
  logic [51:0] tx_head;
  logic        rx_ne;
  logic        tx_ne;
  logic        q_room;
  logic        grant;
  logic        sel_src;

  tsu_ts_arbiter_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(52)) u_rx_fifo (
    .gmii_clk  (gmii_clk),
    .rst       (rst),
    .push      (rx_found),
    .push_data (rx_infor),
    .pop       (grant && !sel_src),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  tsu_ts_arbiter_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(52)) u_tx_fifo (
    .gmii_clk  (gmii_clk),
    .rst       (rst),
    .push      (tx_found),
    .push_data (tx_infor),
    .pop       (grant && sel_src),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  // Registered occupancy flags: a record pushed at edge t is granted at edge t+2.
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      rx_ne <= 1'b0;
      tx_ne <= 1'b0;
    end else begin
      rx_ne <= !rx_empty;
      tx_ne <= !tx_empty;
    end
  end

  assign q_room = ({1'b0, q_wrusedw} < Q_LIMIT);

`ifdef TSU_ARB_RX_PRIORITY_EN
  assign sel_src = !rx_ne;
`else
  // last_grant holds the src bit of the most recent grant; after reset TX wins the first tie.
  logic last_grant;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_src = tx_ne;
    if (rx_ne && tx_ne) sel_src = ~last_grant;
  end

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst)        last_grant <= 1'b0;
    else if (grant) last_grant <= sel_src;
  end
`endif

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    unique case (state)
      IDLE: begin
        if ((rx_ne || tx_ne) && q_room) begin
          grant      = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE:   next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q_wr_en   <= 1'b0;
      q_wr_data <= '0;
    end else begin
      state   <= next_state;
      q_wr_en <= (next_state == WRITE);
      if (grant) q_wr_data <= {3'b000, sel_src, sel_src ? tx_head : rx_head};
    end
  end

  // clr_cnt outranks a coincident drop; counts saturate at 255.
  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      rx_drop_cnt <= '0;
      tx_drop_cnt <= '0;
    end else if (clr_cnt) begin
      rx_drop_cnt <= '0;
      tx_drop_cnt <= '0;
    end else begin
      if (rx_found && rx_full && rx_drop_cnt != 8'hFF) rx_drop_cnt <= rx_drop_cnt + 8'd1;
      if (tx_found && tx_full && tx_drop_cnt != 8'hFF) tx_drop_cnt <= tx_drop_cnt + 8'd1;
    end
  end

endmodule
